// File: rtl/aes_input_loader_pkg.sv
// Shared definitions for the AES input loader.
// Contents:
//   - command encodings carried on cmd;
//   - loader FSM state codes;
//   - word-counter width helper;
//   - parameter legality checks used at elaboration.
package aes_if_pkg;

   // Command encodings (qualified by cmd_valid)
   localparam logic [1:0] CMD_NOP      = 2'd0;
   localparam logic [1:0] CMD_LOAD_PT  = 2'd1;
   localparam logic [1:0] CMD_LOAD_KEY = 2'd2;
   localparam logic [1:0] CMD_START    = 2'd3;

   // Loader FSM states
   typedef logic [1:0] state_t;
   localparam state_t StIdle    = 2'd0;
   localparam state_t StLoadPt  = 2'd1;
   localparam state_t StLoadKey = 2'd2;
   localparam state_t StRun     = 2'd3;

   // Width of a counter that indexes `words` words; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

   function automatic bit legal_din_w(input int unsigned din_w);
      return din_w inside {8, 16, 32, 64};
   endfunction

   function automatic bit legal_key_w(input int unsigned key_w, input int unsigned din_w);
      return (key_w inside {128, 192, 256}) && ((key_w % din_w) == 0);
   endfunction

endpackage

// File: rtl/aes_input_loader_if.sv
// Bus between the host/engine side and the AES input loader.
// Signals:
//   cmd_valid/cmd          command strobe and code (host -> loader)
//   din_valid/din          data word strobe and word, MS word first (host -> loader)
//   engine_done            engine finished the current block (engine -> loader)
//   ready, err             accept indication and error pulse (loader -> host)
//   pt_valid, key_valid    complete plaintext / key held (loader -> host)
//   engine_start           one-cycle start pulse (loader -> engine)
//   plain_out, key_out     assembled plaintext and key (loader -> engine)
// Modports: master = host/engine side, slave = loader.
interface aes_input_loader_if #(
   parameter int unsigned DIN_W = 8,
   parameter int unsigned KEY_W = 128
);
   logic             cmd_valid;
   logic [1:0]       cmd;
   logic             din_valid;
   logic [DIN_W-1:0] din;
   logic             engine_done;
   logic             ready;
   logic             err;
   logic             pt_valid;
   logic             key_valid;
   logic             engine_start;
   logic [127:0]     plain_out;
   logic [KEY_W-1:0] key_out;

   modport master (
      output cmd_valid, cmd, din_valid, din, engine_done,
      input  ready, err, pt_valid, key_valid, engine_start, plain_out, key_out
   );

   modport slave (
      input  cmd_valid, cmd, din_valid, din, engine_done,
      output ready, err, pt_valid, key_valid, engine_start, plain_out, key_out
   );
endinterface

// File: rtl/aes_input_loader_shift.sv
// word_shift_loader: W-bit register assembled from DIN_W-bit words, MS word first.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   clr_i          clear register and word counter (wins over shift_i)
//   shift_i        shift the register left by DIN_W and insert din_i at the LSBs
//   din_i          incoming word
//   data_o         current register contents
//   at_last_o      counter points at the final word; the next shift completes the register
module word_shift_loader
   import aes_if_pkg::*;
#(
   parameter int unsigned W     = 128,
   parameter int unsigned DIN_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             shift_i,
   input  logic [DIN_W-1:0] din_i,
   output logic [W-1:0]     data_o,
   output logic             at_last_o
);

   localparam int unsigned    Words   = W / DIN_W;
   localparam int unsigned    CntW    = cnt_width(Words);
   localparam logic [CntW-1:0] LastCnt = CntW'(Words - 1);

   logic [W-1:0]    data_q, data_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Independent of shift_i so the caller can gate with it without a comb loop.
   assign at_last_o = (cnt_q == LastCnt);
   assign data_o    = data_q;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (shift_i) begin
         data_d = {data_q[W-DIN_W-1:0], din_i};
         // Explicit wrap: Words need not be a power of two (e.g. 192/64).
         cnt_d  = at_last_o ? '0 : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/aes_input_loader.sv
// aes_input_loader: assembles a 128-bit plaintext and a KEY_W-bit key from a DIN_W-bit bus
// and hands them to the AES engine with a one-cycle start pulse. The key survives
// engine completion so successive blocks can reuse it.
// Ports:
//   clk    system clock, rising edge
//   rst_   synchronous reset, active-high
//   bus    loader side (slave modport) of aes_input_loader_if
module aes_input_loader
   import aes_if_pkg::*;
#(
   parameter int unsigned DIN_W   = 8,
   parameter int unsigned KEY_W   = 128,
   parameter int unsigned BLOCK_W = 128
) (
   input logic                clk,
   input logic                rst_,
   aes_input_loader_if.slave  bus
);

   if (!legal_din_w(DIN_W) || !legal_key_w(KEY_W, DIN_W) || (BLOCK_W != 128))
   begin : g_param_err
      $error("aes_input_loader: illegal DIN_W/KEY_W/BLOCK_W combination");
   end

   state_t state_q, state_d;
   logic   pt_valid_q, pt_valid_d;
   logic   key_valid_q, key_valid_d;
   logic   err_q, err_d;
   logic   start_q, start_d;

   logic               pt_clr, pt_shift, pt_at_last;
   logic               key_clr, key_shift, key_at_last;
   logic [BLOCK_W-1:0] pt_data;
   logic [KEY_W-1:0]   key_data;
   logic               cmd_act;

   // A non-NOP command outside RUN is acted on; inside a load it also aborts that load.
   assign cmd_act = bus.cmd_valid && (bus.cmd != CMD_NOP) && (state_q != StRun);

   word_shift_loader #(
      .W     (BLOCK_W),
      .DIN_W (DIN_W)
   ) u_pt_loader (
      .clk_i     (clk),
      .rst_i     (rst_),
      .clr_i     (pt_clr),
      .shift_i   (pt_shift),
      .din_i     (bus.din),
      .data_o    (pt_data),
      .at_last_o (pt_at_last)
   );

   word_shift_loader #(
      .W     (KEY_W),
      .DIN_W (DIN_W)
   ) u_key_loader (
      .clk_i     (clk),
      .rst_i     (rst_),
      .clr_i     (key_clr),
      .shift_i   (key_shift),
      .din_i     (bus.din),
      .data_o    (key_data),
      .at_last_o (key_at_last)
   );

   always_comb begin
      state_d     = state_q;
      pt_valid_d  = pt_valid_q;
      key_valid_d = key_valid_q;
      err_d       = 1'b0;
      start_d     = 1'b0;
      pt_clr      = 1'b0;
      pt_shift    = 1'b0;
      key_clr     = 1'b0;
      key_shift   = 1'b0;

      unique case (state_q)
         StLoadPt: begin
            if (cmd_act) begin
               // Abort: drop the partial plaintext; din this cycle is ignored.
               err_d  = 1'b1;
               pt_clr = 1'b1;
            end else if (bus.din_valid) begin
               pt_shift = 1'b1;
               if (pt_at_last) begin
                  pt_valid_d = 1'b1;
                  state_d    = StIdle;
               end
            end
         end
         StLoadKey: begin
            if (cmd_act) begin
               err_d   = 1'b1;
               key_clr = 1'b1;
            end else if (bus.din_valid) begin
               key_shift = 1'b1;
               if (key_at_last) begin
                  key_valid_d = 1'b1;
                  state_d     = StIdle;
               end
            end
         end
         StRun: begin
            if (bus.engine_done) begin
               pt_valid_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: ;
      endcase

      // Command dispatch, shared by IDLE and by an aborted load in the same cycle.
      if (cmd_act) begin
         state_d = StIdle;
         case (bus.cmd)
            CMD_LOAD_PT: begin
               pt_clr     = 1'b1;
               pt_valid_d = 1'b0;
               state_d    = StLoadPt;
            end
            CMD_LOAD_KEY: begin
               key_clr     = 1'b1;
               key_valid_d = 1'b0;
               state_d     = StLoadKey;
            end
            CMD_START: begin
               // An aborted load always has its own flag at 0, so START is refused there.
               if (pt_valid_q && key_valid_q && (state_q == StIdle)) begin
                  start_d = 1'b1;
                  state_d = StRun;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q     <= StIdle;
         pt_valid_q  <= 1'b0;
         key_valid_q <= 1'b0;
         err_q       <= 1'b0;
         start_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pt_valid_q  <= pt_valid_d;
         key_valid_q <= key_valid_d;
         err_q       <= err_d;
         start_q     <= start_d;
      end
   end

   assign bus.ready        = (state_q != StRun);
   assign bus.err          = err_q;
   assign bus.pt_valid     = pt_valid_q;
   assign bus.key_valid    = key_valid_q;
   assign bus.engine_start = start_q;
   assign bus.plain_out    = pt_data;
   assign bus.key_out      = key_data;

   // The start pulse is only ever raised together with entry into RUN.
   a_start_in_run: assert property (@(posedge clk) start_q |-> (state_q == StRun));
   a_start_no_err: assert property (@(posedge clk) start_q |-> !err_q);

endmodule

// File: tb/tb_aes_input_loader.sv
module tb_aes_input_loader;
   import aes_if_pkg::*;

   logic clk = 1'b0;
   logic rst_ = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   aes_input_loader_if #(.DIN_W(8), .KEY_W(128)) a ();
   aes_input_loader_if #(.DIN_W(32), .KEY_W(256)) b ();

   aes_input_loader #(.DIN_W(8), .KEY_W(128), .BLOCK_W(128)) dut_a (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (a)
   );

   aes_input_loader #(.DIN_W(32), .KEY_W(256), .BLOCK_W(128)) dut_b (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (b)
   );

   always #5 clk = ~clk;

   // Reference model of DUT a at transaction level: register contents and flags.
   logic [127:0] m_pt, m_key;
   logic         m_pt_v, m_key_v;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      a.cmd_valid = 1'b0; a.cmd = CMD_NOP; a.din_valid = 1'b0; a.din = '0;
      a.engine_done = 1'b0;
   endtask

   task automatic idle_b();
      b.cmd_valid = 1'b0; b.cmd = CMD_NOP; b.din_valid = 1'b0; b.din = '0;
      b.engine_done = 1'b0;
   endtask

   task automatic cmd_a(input logic [1:0] c);
      a.cmd_valid = 1'b1; a.cmd = c;
      tick();
      a.cmd_valid = 1'b0; a.cmd = CMD_NOP;
   endtask

   task automatic word_a(input logic [7:0] w);
      a.din_valid = 1'b1; a.din = w;
      tick();
      a.din_valid = 1'b0;
   endtask

   // Value of a register after loading v[0..15], MS word first.
   function automatic logic [127:0] pack8(input logic [7:0] v [16]);
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++) r = (r << 8) | 128'(v[i]);
      return r;
   endfunction

   task automatic load_a(input logic [1:0] c, input logic [7:0] v [16]);
      cmd_a(c);
      for (int i = 0; i < 16; i++) word_a(v[i]);
   endtask

   task automatic do_reset();
      rst_ = 1'b1;
      tick();
      rst_ = 1'b0;
      m_pt = '0; m_key = '0; m_pt_v = 1'b0; m_key_v = 1'b0;
   endtask

   task automatic test_reset();
      // Busy inputs while in reset must be ignored.
      rst_ = 1'b1;
      a.cmd_valid = 1'b1; a.cmd = CMD_LOAD_KEY; a.din_valid = 1'b1; a.din = 8'($urandom);
      a.engine_done = 1'b1;
      b.cmd_valid = 1'b1; b.cmd = CMD_START; b.din_valid = 1'b1; b.din = $urandom;
      tick(); tick();
      idle_a(); idle_b();
      rst_ = 1'b0;
      m_pt = '0; m_key = '0; m_pt_v = 1'b0; m_key_v = 1'b0;
      n_checks++;
      if ({a.ready, a.err, a.pt_valid, a.key_valid, a.engine_start} !== 5'b10000) begin
         n_errors++;
         $display("FAIL reset_flags: got %b want 10000",
                  {a.ready, a.err, a.pt_valid, a.key_valid, a.engine_start});
      end
      n_checks++;
      if ({a.plain_out, a.key_out} !== 256'd0) begin
         n_errors++;
         $display("FAIL reset_data: got pt=%h key=%h want 0", a.plain_out, a.key_out);
      end
      n_checks++;
      if ({b.ready, b.err, b.key_valid, b.engine_start} !== 4'b1000 || b.key_out !== 256'd0) begin
         n_errors++;
         $display("FAIL reset_wide: got flags=%b key=%h want 1000/0",
                  {b.ready, b.err, b.key_valid, b.engine_start}, b.key_out);
      end
      // A LOAD_KEY held during reset must not have moved the FSM: din now is still ignored.
      a.din_valid = 1'b1; a.din = 8'hA5;
      tick();
      idle_a();
      n_checks++;
      if (a.key_out !== 128'd0) begin
         n_errors++;
         $display("FAIL reset_din_ignored: got key=%h want 0", a.key_out);
      end
   endtask

   task automatic test_basic();
      logic [7:0] v [16];
      int         k;
      cmd_a(CMD_LOAD_KEY);
      for (int i = 0; i < 16; i++) begin
         word_a(8'(i));
         if (i == 14) begin
            n_checks++;
            if (a.key_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL basic_key_early: got key_valid=%b want 0", a.key_valid);
            end
         end
      end
      n_checks++;
      if (a.key_valid !== 1'b1 || a.key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin
         n_errors++;
         $display("FAIL basic_key: got v=%b key=%h want 1/000102..0f", a.key_valid, a.key_out);
      end
      for (int i = 0; i < 16; i++) v[i] = 8'(8'h10 + i);
      load_a(CMD_LOAD_PT, v);
      n_checks++;
      if (a.pt_valid !== 1'b1 || a.plain_out !== 128'h101112131415161718191a1b1c1d1e1f) begin
         n_errors++;
         $display("FAIL basic_pt: got v=%b pt=%h want 1/101112..1f", a.pt_valid, a.plain_out);
      end
      m_key = 128'h000102030405060708090a0b0c0d0e0f; m_key_v = 1'b1;
      m_pt = pack8(v); m_pt_v = 1'b1;
      cmd_a(CMD_START);
      n_checks++;
      if (a.engine_start !== 1'b1 || a.ready !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_start: got start=%b ready=%b want 1/0", a.engine_start, a.ready);
      end
      // RUN: random command/data traffic must be ignored, outputs held.
      k = $urandom_range(2, 6);
      for (int i = 0; i < k; i++) begin
         a.cmd_valid = 1'($urandom); a.cmd = 2'($urandom);
         a.din_valid = 1'($urandom); a.din = 8'($urandom);
         tick();
         n_checks++;
         if (a.engine_start !== 1'b0 || a.ready !== 1'b0 || a.err !== 1'b0 ||
             a.plain_out !== m_pt || a.key_out !== m_key) begin
            n_errors++;
            $display("FAIL basic_run_hold: got start=%b ready=%b err=%b pt=%h want 0/0/0/%h",
                     a.engine_start, a.ready, a.err, a.plain_out, m_pt);
         end
      end
      idle_a();
      a.engine_done = 1'b1;
      tick();
      a.engine_done = 1'b0;
      m_pt_v = 1'b0;
      n_checks++;
      if (a.ready !== 1'b1 || a.pt_valid !== 1'b0 || a.key_valid !== 1'b1 ||
          a.key_out !== m_key) begin
         n_errors++;
         $display("FAIL basic_done: got ready=%b ptv=%b keyv=%b key=%h want 1/0/1/%h",
                  a.ready, a.pt_valid, a.key_valid, a.key_out, m_key);
      end
   endtask

   task automatic test_start_refused();
      logic [7:0] v [16];
      logic       seen;
      do_reset();
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      load_a(CMD_LOAD_KEY, v);
      cmd_a(CMD_START);
      n_checks++;
      if (a.err !== 1'b1 || a.engine_start !== 1'b0 || a.ready !== 1'b1) begin
         n_errors++;
         $display("FAIL refused_err: got err=%b start=%b ready=%b want 1/0/1",
                  a.err, a.engine_start, a.ready);
      end
      seen = 1'b0;
      tick();
      n_checks++;
      if (a.err !== 1'b0) begin
         n_errors++;
         $display("FAIL refused_err_width: got err=%b want 0", a.err);
      end
      for (int i = 0; i < 4; i++) begin
         seen |= a.engine_start | ~a.ready;
         tick();
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_errors++;
         $display("FAIL refused_no_start: got start_or_busy=%b want 0", seen);
      end
      m_key = pack8(v); m_key_v = 1'b1;
   endtask

   task automatic test_abort();
      logic [7:0] v [16];
      cmd_a(CMD_LOAD_PT);
      for (int i = 0; i < 5; i++) word_a(8'($urandom));
      // Restart with a LOAD_PT carrying a din that must be dropped.
      a.cmd_valid = 1'b1; a.cmd = CMD_LOAD_PT; a.din_valid = 1'b1; a.din = 8'($urandom);
      tick();
      idle_a();
      n_checks++;
      if (a.err !== 1'b1 || a.pt_valid !== 1'b0 || a.plain_out !== 128'd0) begin
         n_errors++;
         $display("FAIL abort_pt: got err=%b ptv=%b pt=%h want 1/0/0",
                  a.err, a.pt_valid, a.plain_out);
      end
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) word_a(v[i]);
      m_pt = pack8(v); m_pt_v = 1'b1;
      n_checks++;
      if (a.pt_valid !== 1'b1 || a.plain_out !== m_pt || a.err !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_reload: got v=%b pt=%h err=%b want 1/%h/0",
                  a.pt_valid, a.plain_out, a.err, m_pt);
      end
      // Abort a key load with START: refused, key invalid.
      cmd_a(CMD_LOAD_KEY);
      for (int i = 0; i < 3; i++) word_a(8'($urandom));
      cmd_a(CMD_START);
      m_key = '0; m_key_v = 1'b0;
      n_checks++;
      if (a.err !== 1'b1 || a.engine_start !== 1'b0 || a.key_valid !== 1'b0 ||
          a.key_out !== 128'd0 || a.ready !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_start: got err=%b start=%b keyv=%b key=%h ready=%b want 1/0/0/0/1",
                  a.err, a.engine_start, a.key_valid, a.key_out, a.ready);
      end
   endtask

   task automatic test_key_reuse();
      logic [7:0] v [16];
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      load_a(CMD_LOAD_KEY, v);
      m_key = pack8(v); m_key_v = 1'b1;
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      load_a(CMD_LOAD_PT, v);
      m_pt = pack8(v); m_pt_v = 1'b1;
      cmd_a(CMD_START);
      tick();
      a.engine_done = 1'b1; tick(); a.engine_done = 1'b0;
      m_pt_v = 1'b0;
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      load_a(CMD_LOAD_PT, v);
      m_pt = pack8(v); m_pt_v = 1'b1;
      // engine_done outside RUN is ignored.
      a.engine_done = 1'b1; tick(); a.engine_done = 1'b0;
      n_checks++;
      if (a.pt_valid !== 1'b1 || a.key_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL reuse_done_idle: got ptv=%b keyv=%b want 1/1", a.pt_valid, a.key_valid);
      end
      cmd_a(CMD_START);
      n_checks++;
      if (a.engine_start !== 1'b1 || a.key_out !== m_key || a.plain_out !== m_pt) begin
         n_errors++;
         $display("FAIL reuse_start: got start=%b key=%h pt=%h want 1/%h/%h",
                  a.engine_start, a.key_out, a.plain_out, m_key, m_pt);
      end
      a.engine_done = 1'b1; tick(); a.engine_done = 1'b0;
      m_pt_v = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] v [16];
      logic [1:0] c;
      int         op, n;
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 4);
         case (op)
            0, 1: begin
               for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
               c = (op == 0) ? CMD_LOAD_PT : CMD_LOAD_KEY;
               load_a(c, v);
               if (op == 0) begin m_pt = pack8(v); m_pt_v = 1'b1; end
               else begin m_key = pack8(v); m_key_v = 1'b1; end
            end
            2: begin
               c = ($urandom_range(0, 1) == 0) ? CMD_LOAD_PT : CMD_LOAD_KEY;
               n = $urandom_range(1, 15);
               cmd_a(c);
               for (int i = 0; i < n; i++) word_a(8'($urandom));
               a.din_valid = 1'b1; a.din = 8'($urandom);
               cmd_a(CMD_START);
               a.din_valid = 1'b0;
               if (c == CMD_LOAD_PT) begin m_pt = '0; m_pt_v = 1'b0; end
               else begin m_key = '0; m_key_v = 1'b0; end
               n_checks++;
               if (a.err !== 1'b1 || a.engine_start !== 1'b0) begin
                  n_errors++;
                  $display("FAIL rand_abort[%0d]: got err=%b start=%b want 1/0",
                           it, a.err, a.engine_start);
               end
            end
            3: begin
               cmd_a(CMD_START);
               n_checks++;
               if ({a.engine_start, a.err} !== {m_pt_v & m_key_v, ~(m_pt_v & m_key_v)}) begin
                  n_errors++;
                  $display("FAIL rand_start[%0d]: got start=%b err=%b want %b/%b", it,
                           a.engine_start, a.err, m_pt_v & m_key_v, ~(m_pt_v & m_key_v));
               end
               if (m_pt_v && m_key_v) begin
                  n = $urandom_range(0, 3);
                  for (int i = 0; i < n; i++) tick();
                  a.engine_done = 1'b1; tick(); a.engine_done = 1'b0;
                  m_pt_v = 1'b0;
               end
            end
            default: begin
               for (int i = 0; i < 3; i++) begin
                  a.din_valid = 1'($urandom); a.din = 8'($urandom);
                  a.cmd_valid = 1'($urandom); a.cmd = CMD_NOP;
                  tick();
               end
               idle_a();
            end
         endcase
         tick();
         n_checks++;
         if ({a.ready, a.pt_valid, a.key_valid} !== {1'b1, m_pt_v, m_key_v} ||
             a.plain_out !== m_pt || a.key_out !== m_key) begin
            n_errors++;
            $display("FAIL rand_state[%0d]: got rdy=%b ptv=%b keyv=%b pt=%h key=%h want %b%b pt=%h key=%h",
                     it, a.ready, a.pt_valid, a.key_valid, a.plain_out, a.key_out,
                     m_pt_v, m_key_v, m_pt, m_key);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v [16];
      logic       seen;
      for (int i = 0; i < 16; i++) v[i] = 8'($urandom);
      load_a(CMD_LOAD_KEY, v);
      load_a(CMD_LOAD_PT, v);
      cmd_a(CMD_START);
      // Reset in RUN together with other activity.
      rst_ = 1'b1;
      a.cmd_valid = 1'b1; a.cmd = CMD_START; a.din_valid = 1'b1; a.engine_done = 1'b1;
      tick();
      idle_a(); rst_ = 1'b0;
      n_checks++;
      if ({a.ready, a.err, a.pt_valid, a.key_valid, a.engine_start} !== 5'b10000 ||
          {a.plain_out, a.key_out} !== 256'd0) begin
         n_errors++;
         $display("FAIL rst_run: got flags=%b pt=%h key=%h want 10000/0/0",
                  {a.ready, a.err, a.pt_valid, a.key_valid, a.engine_start},
                  a.plain_out, a.key_out);
      end
      cmd_a(CMD_LOAD_KEY);
      for (int i = 0; i < 6; i++) word_a(8'($urandom));
      rst_ = 1'b1; a.din_valid = 1'b1; a.din = 8'($urandom);
      tick();
      idle_a(); rst_ = 1'b0;
      n_checks++;
      if ({a.ready, a.err, a.key_valid} !== 3'b100 || a.key_out !== 128'd0) begin
         n_errors++;
         $display("FAIL rst_load_key: got flags=%b key=%h want 100/0",
                  {a.ready, a.err, a.key_valid}, a.key_out);
      end
      // START coinciding with reset: the start pulse is suppressed.
      load_a(CMD_LOAD_KEY, v);
      load_a(CMD_LOAD_PT, v);
      rst_ = 1'b1; a.cmd_valid = 1'b1; a.cmd = CMD_START;
      tick();
      seen = a.engine_start;
      idle_a(); rst_ = 1'b0;
      tick();
      seen |= a.engine_start | a.pt_valid | a.key_valid;
      n_checks++;
      if (seen !== 1'b0) begin
         n_errors++;
         $display("FAIL rst_start: got start_or_valid=%b want 0", seen);
      end
      m_pt = '0; m_key = '0; m_pt_v = 1'b0; m_key_v = 1'b0;
   endtask

   task automatic test_wide();
      logic [31:0]  w [8];
      logic [255:0] exp_key;
      w[0] = 32'h00112233;
      w[7] = 32'hEEFF0011;
      for (int i = 1; i < 7; i++) w[i] = $urandom;
      exp_key = '0;
      for (int i = 0; i < 8; i++) exp_key = (exp_key << 32) | 256'(w[i]);
      b.cmd_valid = 1'b1; b.cmd = CMD_LOAD_KEY; tick(); b.cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b.din_valid = 1'b1; b.din = w[i]; tick(); b.din_valid = 1'b0;
         if (i == 6) begin
            n_checks++;
            if (b.key_valid !== 1'b0) begin
               n_errors++;
               $display("FAIL wide_early: got key_valid=%b want 0", b.key_valid);
            end
         end
      end
      n_checks++;
      if (b.key_valid !== 1'b1 || b.key_out !== exp_key) begin
         n_errors++;
         $display("FAIL wide_key: got v=%b key=%h want 1/%h", b.key_valid, b.key_out, exp_key);
      end
      b.din_valid = 1'b1; b.din = $urandom; tick(); b.din_valid = 1'b0;
      n_checks++;
      if (b.key_valid !== 1'b1 || b.key_out !== exp_key || b.err !== 1'b0) begin
         n_errors++;
         $display("FAIL wide_ninth: got v=%b key=%h err=%b want 1/%h/0",
                  b.key_valid, b.key_out, b.err, exp_key);
      end
      b.cmd_valid = 1'b1; b.cmd = CMD_START; tick(); b.cmd_valid = 1'b0;
      n_checks++;
      if (b.err !== 1'b1 || b.engine_start !== 1'b0) begin
         n_errors++;
         $display("FAIL wide_refused: got err=%b start=%b want 1/0", b.err, b.engine_start);
      end
      idle_b();
   endtask

   initial begin
      idle_a();
      idle_b();
      test_reset();
      test_basic();
      test_start_refused();
      test_abort();
      test_key_reuse();
      test_random();
      test_reset_mid();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
